// File: rtl/reg_32_deser.sv
// Serial-to-parallel receiver for the MSB-first shift link: assembles WIDTH-bit
// words from ShiftIn and offers them on a one-deep Valid/Ready holding slot.
module reg_32_deser #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             ShiftIn,
  input  logic             Shift_En,
  input  logic             Ready,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  output logic             Busy,
  output logic [CW-1:0]    Count,
  output logic             Overrun
);

  // The oldest bit of a word is consumed straight out of the shifter on the
  // completing edge, so only WIDTH-1 bits ever need to be held.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             slot_free;

  assign word      = {shreg, ShiftIn};
  assign last_bit  = Shift_En && (Count == CW'(WIDTH - 1));
  assign slot_free = !Valid || Ready;
  assign Busy      = (Count != '0);

  // The control states (idle, shift, hold, shift+hold) are fully described by
  // Count and Valid, so no separate state register is kept.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg    <= '0;
      Count    <= '0;
      Data_Out <= '0;
      Valid    <= 1'b0;
      Overrun  <= 1'b0;
    end else if (Clear) begin
      shreg    <= '0;
      Count    <= '0;
      Data_Out <= '0;
      Valid    <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every branch reading pre-edge
      // values of Count and Valid, which the completion/handshake overlap needs.
      if (Shift_En) begin
        shreg <= word[WIDTH-2:0];
        Count <= last_bit ? '0 : Count + CW'(1);
      end

      if (last_bit) begin
        if (slot_free) begin
          Data_Out <= word;
          Valid    <= 1'b1;
        end else begin
          Overrun  <= 1'b1;
        end
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_32_deser.sv
// Self-checking bench for reg_32_deser: test-plan sequences, a vector table and
// randomized traffic, all compared against a bit-queue reference model.
module tb_reg_32_deser;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH);

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Clear;
  logic             ShiftIn;
  logic             Shift_En;
  logic             Ready;
  logic [WIDTH-1:0] Data_Out;
  logic             Valid;
  logic             Busy;
  logic [CW-1:0]    Count;
  logic             Overrun;

  reg_32_deser #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Clear    (Clear),
    .ShiftIn  (ShiftIn),
    .Shift_En (Shift_En),
    .Ready    (Ready),
    .Data_Out (Data_Out),
    .Valid    (Valid),
    .Busy     (Busy),
    .Count    (Count),
    .Overrun  (Overrun)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: received bits kept in a queue, word built arithmetically.
  bit               q[$];
  logic [WIDTH-1:0] m_data;
  bit               m_valid;
  bit               m_ovr;

  function automatic void model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  function automatic void model_edge(bit clr, bit se, bit si, bit rdy);
    logic [WIDTH-1:0] w;
    bit done;
    w    = '0;
    done = 1'b0;
    if (clr) begin
      model_reset();
      return;
    end
    if (se) begin
      q.push_back(si);
      if (q.size() == WIDTH) begin
        foreach (q[i]) w = (w << 1) | WIDTH'(q[i]);
        q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic compare_model();
    check("model.data",    64'(Data_Out), 64'(m_data));
    check("model.valid",   64'(Valid),    64'(m_valid));
    check("model.count",   64'(Count),    64'(q.size()));
    check("model.busy",    64'(Busy),     64'(q.size() != 0));
    check("model.overrun", 64'(Overrun),  64'(m_ovr));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit se, input bit si, input bit rdy, input bit clr = 1'b0);
    Shift_En = se;
    ShiftIn  = si;
    Ready    = rdy;
    Clear    = clr;
    model_edge(clr, se, si, rdy);
    @(posedge Clk);
    #1;
    if (Valid) valid_cycles++;
    compare_model();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int max_gap, input bit rdy);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) cyc(1'b0, 1'($urandom_range(1, 0)), rdy);
      cyc(1'b1, w[i], rdy);
    end
  endtask

  task automatic expect_out(input string tag, input logic [WIDTH-1:0] d, input bit v,
                            input int cnt, input bit ovr);
    check({tag, ".data"},    64'(Data_Out), 64'(d));
    check({tag, ".valid"},   64'(Valid),    64'(v));
    check({tag, ".count"},   64'(Count),    64'(cnt));
    check({tag, ".busy"},    64'(Busy),     64'(cnt != 0));
    check({tag, ".overrun"}, 64'(Overrun),  64'(ovr));
  endtask

  typedef struct {
    bit               clr;
    logic [WIDTH-1:0] word;
    int               max_gap;
    bit               rdy;
    logic [WIDTH-1:0] exp_data;
    bit               exp_valid;
    bit               exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{clr: 1, word: 32'h0000_0001, max_gap: 0, rdy: 0, exp_data: 32'h0000_0001, exp_valid: 1, exp_ovr: 0};
    vecs[1] = '{clr: 0, word: 32'hFFFF_FFFF, max_gap: 2, rdy: 0, exp_data: 32'h0000_0001, exp_valid: 1, exp_ovr: 1};
    vecs[2] = '{clr: 0, word: 32'h7FFF_FFFE, max_gap: 1, rdy: 1, exp_data: 32'h7FFF_FFFE, exp_valid: 1, exp_ovr: 1};
    vecs[3] = '{clr: 0, word: 32'h8000_0000, max_gap: 3, rdy: 1, exp_data: 32'h8000_0000, exp_valid: 1, exp_ovr: 1};
    vecs[4] = '{clr: 1, word: 32'h0000_0000, max_gap: 0, rdy: 0, exp_data: 32'h0000_0000, exp_valid: 1, exp_ovr: 0};
    vecs[5] = '{clr: 0, word: 32'h1357_9BDF, max_gap: 4, rdy: 1, exp_data: 32'h1357_9BDF, exp_valid: 1, exp_ovr: 0};

    Reset_n  = 1'b0;
    Clear    = 1'b0;
    ShiftIn  = 1'b0;
    Shift_En = 1'b0;
    Ready    = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    expect_out("reset", '0, 1'b0, 0, 1'b0);
    Reset_n = 1'b1;

    // Contiguous word after reset release.
    send_word(32'hDEAD_BEEF, 0, 1'b0);
    expect_out("deadbeef", 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("deadbeef.consumed", 64'(Valid), 64'(0));

    // Gapped word held with Ready low, then released.
    send_word(32'h1234_5678, 5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("hold.valid", 64'(Valid),    64'(1));
      check("hold.data",  64'(Data_Out), 64'(32'h1234_5678));
    end
    cyc(1'b0, 1'b0, 1'b1);
    check("hold.released", 64'(Valid), 64'(0));

    // Back-to-back words with Ready high throughout: one Valid cycle each.
    valid_cycles = 0;
    send_word(32'hA5A5_A5A5, 0, 1'b1);
    check("b2b.first", 64'(Data_Out), 64'(32'hA5A5_A5A5));
    send_word(32'h0F0F_0F0F, 0, 1'b1);
    check("b2b.second", 64'(Data_Out), 64'(32'h0F0F_0F0F));
    cyc(1'b0, 1'b0, 1'b1);
    check("b2b.valid_cycles", 64'(valid_cycles), 64'(2));

    // Completion on the same edge the held word is consumed.
    send_word(32'hA5A5_A5A5, 0, 1'b0);
    for (int i = WIDTH - 1; i >= 1; i--) cyc(1'b1, 1'(32'h0F0F_0F0F >> i), 1'b0);
    check("refill.held", 64'(Data_Out), 64'(32'hA5A5_A5A5));
    cyc(1'b1, 1'b1, 1'b1);
    expect_out("refill", 32'h0F0F_0F0F, 1'b1, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("refill.consumed", 64'(Valid), 64'(0));

    // Overrun: second word dropped, flag sticky until Clear.
    send_word(32'h1111_1111, 0, 1'b0);
    send_word(32'h2222_2222, 1, 1'b0);
    expect_out("overrun", 32'h1111_1111, 1'b1, 0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("overrun.valid_after_ready", 64'(Valid), 64'(0));
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    check("overrun.sticky", 64'(Overrun), 64'(1));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("overrun.cleared", 64'(Overrun), 64'(0));

    // Clear mid-word discards the partial word.
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0);
    check("partial.count", 64'(Count), 64'(17));
    check("partial.busy",  64'(Busy),  64'(1));
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    expect_out("clear", '0, 1'b0, 0, 1'b0);
    send_word(32'h8000_0001, 0, 1'b0);
    check("after_clear.data", 64'(Data_Out), 64'(32'h8000_0001));

    // Asynchronous reset mid-cycle while a word is held and another is partial.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    check("pre_reset.count", 64'(Count), 64'(9));
    check("pre_reset.valid", 64'(Valid), 64'(1));
    #2;
    Reset_n = 1'b0;
    #1;
    expect_out("async_reset", '0, 1'b0, 0, 1'b0);
    model_reset();
    #1;
    Reset_n = 1'b1;
    send_word(32'hCAFE_F00D, 0, 1'b0);
    check("after_reset.data", 64'(Data_Out), 64'(32'hCAFE_F00D));

    // Vector table.
    foreach (vecs[i]) begin
      if (vecs[i].clr) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      send_word(vecs[i].word, vecs[i].max_gap, vecs[i].rdy);
      check("vec.data",    64'(Data_Out), 64'(vecs[i].exp_data));
      check("vec.valid",   64'(Valid),    64'(vecs[i].exp_valid));
      check("vec.overrun", 64'(Overrun),  64'(vecs[i].exp_ovr));
    end

    // Randomized traffic against the model.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
          1'($urandom_range(2, 0) == 0), 1'($urandom_range(499, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
